// File: rtl/ad_frame_align.sv
`default_nettype none
// ============================================================================
//  Module   : ad_frame_align
//  Purpose  : Bitslip-based frame alignment of the ISERDESE2 FCO word, with
//             lock monitoring, re-alignment and failure reporting.
//  Revision : 1.0  initial release
// ============================================================================
module ad_frame_align #(
  parameter logic [7:0] PATTERN   = 8'hF0,
  parameter int unsigned SLIP_WAIT = 8,
  parameter int unsigned MATCH_CNT = 16,
  parameter int unsigned MAX_SLIP  = 8,
  parameter int unsigned LOSS_CNT  = 4
) (
  input  logic        clk_div_in,
  input  logic        rst_n_in,
  input  logic        dly_rdy_in,
  input  logic        re_align_in,
  input  logic [7:0]  frame_in,
  output logic        bitslip_out,
  output logic        aligned_out,
  output logic        align_fail_out,
  output logic [2:0]  slip_cnt_out,
  output logic [15:0] lock_loss_cnt_out,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_SLIP   = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam logic [7:0]  c_WAIT_LOAD = 8'(SLIP_WAIT - 1);
  localparam logic [15:0] c_MATCH_TGT = 16'(MATCH_CNT);
  localparam logic [7:0]  c_MAX_SLIP  = 8'(MAX_SLIP);
  localparam logic [7:0]  c_LOSS_TGT  = 8'(LOSS_CNT);

  state_t      r_state;
  logic [7:0]  r_frame_q;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_match_cnt;
  logic [7:0]  r_slips_done;
  logic [7:0]  r_miss_cnt;
  logic        r_bitslip;
  logic        r_aligned;
  logic        r_fail;
  logic [2:0]  r_slip_cnt;
  logic [15:0] r_loss_cnt;

  logic        w_match;
  logic        w_abort;
  logic [15:0] w_match_inc;
  logic [7:0]  w_miss_inc;

  assign w_match     = (r_frame_q == PATTERN);
  // Losing IDELAYCTRL ready restarts alignment exactly like an explicit request
  assign w_abort     = re_align_in || (!dly_rdy_in && (r_state != S_IDLE));
  assign w_match_inc = r_match_cnt + 16'd1;
  assign w_miss_inc  = r_miss_cnt + 8'd1;

  always_ff @(posedge clk_div_in) begin
    if (!rst_n_in) begin
      r_state      <= S_IDLE;
      r_frame_q    <= 8'd0;
      r_wait_cnt   <= 8'd0;
      r_match_cnt  <= 16'd0;
      r_slips_done <= 8'd0;
      r_miss_cnt   <= 8'd0;
      r_bitslip    <= 1'b0;
      r_aligned    <= 1'b0;
      r_fail       <= 1'b0;
      r_slip_cnt   <= 3'd0;
      r_loss_cnt   <= 16'd0;
    end else begin
      r_frame_q <= frame_in;
      r_bitslip <= 1'b0;
      if (w_abort) begin
        r_state      <= S_IDLE;
        r_aligned    <= 1'b0;
        r_fail       <= 1'b0;
        r_slip_cnt   <= 3'd0;
        r_slips_done <= 8'd0;
        r_match_cnt  <= 16'd0;
        r_miss_cnt   <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (dly_rdy_in) begin
              r_state    <= S_SETTLE;
              r_wait_cnt <= c_WAIT_LOAD;
            end
          end
          S_SETTLE: begin
            if (r_wait_cnt == 8'd0) begin
              r_state     <= S_CHECK;
              r_match_cnt <= 16'd0;
            end else begin
              r_wait_cnt <= r_wait_cnt - 8'd1;
            end
          end
          S_CHECK: begin
            if (w_match) begin
              r_match_cnt <= w_match_inc;
              if (w_match_inc == c_MATCH_TGT) begin
                r_state    <= S_LOCKED;
                r_aligned  <= 1'b1;
                r_miss_cnt <= 8'd0;
              end
            end else begin
              r_match_cnt <= 16'd0;
              if (r_slips_done == c_MAX_SLIP) begin
                r_state <= S_FAIL;
                r_fail  <= 1'b1;
              end else begin
                r_state   <= S_SLIP;
                r_bitslip <= 1'b1;
              end
            end
          end
          S_SLIP: begin
            r_slips_done <= r_slips_done + 8'd1;
            r_slip_cnt   <= r_slip_cnt + 3'd1;
            r_state      <= S_SETTLE;
            r_wait_cnt   <= c_WAIT_LOAD;
          end
          S_LOCKED: begin
            if (w_match) begin
              r_miss_cnt <= 8'd0;
            end else if (w_miss_inc == c_LOSS_TGT) begin
              // Lock lost: re-settle from the current slip position, keep slip_cnt
              r_aligned    <= 1'b0;
              r_miss_cnt   <= 8'd0;
              r_slips_done <= 8'd0;
              r_state      <= S_SETTLE;
              r_wait_cnt   <= c_WAIT_LOAD;
              if (r_loss_cnt != 16'hFFFF) begin
                r_loss_cnt <= r_loss_cnt + 16'd1;
              end
            end else begin
              r_miss_cnt <= w_miss_inc;
            end
          end
          S_FAIL: begin
            r_state <= S_FAIL;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bitslip_out       = r_bitslip;
  assign aligned_out       = r_aligned;
  assign align_fail_out    = r_fail;
  assign slip_cnt_out      = r_slip_cnt;
  assign lock_loss_cnt_out = r_loss_cnt;
  assign state_out         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ad_frame_align.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ad_frame_align
//  Purpose  : Self-checking bench for ad_frame_align (scenario table plus
//             hand-written multi-cycle sequences).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ad_frame_align;

  localparam logic [7:0] c_PAT  = 8'hF0;
  localparam int         c_WAIT = 8;

  logic        clk_div_in = 1'b0;
  logic        rst_n_in;
  logic        dly_rdy_in;
  logic        re_align_in;
  logic [7:0]  frame_in;
  logic        bitslip_out;
  logic        aligned_out;
  logic        align_fail_out;
  logic [2:0]  slip_cnt_out;
  logic [15:0] lock_loss_cnt_out;
  logic [2:0]  state_out;

  int n_cmp = 0;
  int n_bad = 0;

  ad_frame_align dut (
    .clk_div_in       (clk_div_in),
    .rst_n_in         (rst_n_in),
    .dly_rdy_in       (dly_rdy_in),
    .re_align_in      (re_align_in),
    .frame_in         (frame_in),
    .bitslip_out      (bitslip_out),
    .aligned_out      (aligned_out),
    .align_fail_out   (align_fail_out),
    .slip_cnt_out     (slip_cnt_out),
    .lock_loss_cnt_out(lock_loss_cnt_out),
    .state_out        (state_out)
  );

  always #5 clk_div_in = ~clk_div_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // rot=1: the bench rotates its word left on every bitslip pulse.
  // exp_cycles counts posedges from the first edge that sees dly_rdy_in=1.
  typedef struct {
    string      name;
    bit         rot;
    logic [7:0] word;
    int         exp_pulses;
    bit         exp_aligned;
    bit         exp_fail;
    logic [2:0] exp_slip;
    int         exp_cycles;
  } vec_t;

  vec_t tbl[5];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in    = 1'b0;
    dly_rdy_in  = 1'b0;
    re_align_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
  endtask

  task automatic wait_state(input string name, input logic [2:0] st, input int budget);
    for (int k = 0; k < budget && state_out != st; k++) tick();
    check(name, 32'(state_out), 32'(st));
  endtask

  task automatic run_scenario(input vec_t v);
    int n, pulses, last;
    bit done;
    vec_t e;
    do_reset();
    frame_in   = v.word;
    sb.push_back(v);
    dly_rdy_in = 1'b1;
    n = 0; pulses = 0; last = -100; done = 0;
    while (!done && n < 300) begin
      tick();
      n++;
      if (bitslip_out) begin
        if (pulses > 0) check({v.name, "_slip_gap_ok"}, 32'(n - last >= c_WAIT + 1), 32'd1);
        last = n;
        pulses++;
        if (v.rot) frame_in = {frame_in[6:0], frame_in[7]};
      end
      check({v.name, "_aligned_and_fail"}, 32'(aligned_out & align_fail_out), 32'd0);
      if (aligned_out || align_fail_out) done = 1;
    end
    e = sb.pop_front();
    check({e.name, "_cycles"},  32'(n),              32'(e.exp_cycles));
    check({e.name, "_pulses"},  32'(pulses),         32'(e.exp_pulses));
    check({e.name, "_aligned"}, 32'(aligned_out),    32'(e.exp_aligned));
    check({e.name, "_fail"},    32'(align_fail_out), 32'(e.exp_fail));
    check({e.name, "_slipcnt"}, 32'(slip_cnt_out),   32'(e.exp_slip));
    check({e.name, "_state"},   32'(state_out),      e.exp_aligned ? 32'd4 : 32'd5);
  endtask

  task automatic wait_aligned(input string name, input int budget);
    for (int k = 0; k < budget && !aligned_out; k++) tick();
    check(name, 32'(aligned_out), 32'd1);
  endtask

  task automatic lose_lock(input string name);
    frame_in = 8'h00;
    wait_state({name, "_settle"}, 3'd1, 12);
    check({name, "_aligned_low"}, 32'(aligned_out), 32'd0);
    frame_in = c_PAT;
    wait_aligned({name, "_relock"}, 40);
  endtask

  initial begin
    // Lock at 1 + SLIP_WAIT + MATCH_CNT edges; every slip adds CHECK+SLIP+SETTLE = 10.
    tbl[0] = '{"direct", 1'b1, 8'hF0, 0, 1'b1, 1'b0, 3'd0, 25};
    tbl[1] = '{"slip3",  1'b1, 8'h1E, 3, 1'b1, 1'b0, 3'd3, 55};
    tbl[2] = '{"slip7",  1'b1, 8'hE1, 7, 1'b1, 1'b0, 3'd7, 95};
    tbl[3] = '{"zeros",  1'b0, 8'h00, 8, 1'b0, 1'b1, 3'd0, 90};
    tbl[4] = '{"alt",    1'b0, 8'hAA, 8, 1'b0, 1'b1, 3'd0, 90};

    frame_in = 8'h00;
    do_reset();
    check("rst_state",   32'(state_out),         32'd0);
    check("rst_outputs", 32'({bitslip_out, aligned_out, align_fail_out, slip_cnt_out}), 32'd0);
    check("rst_losscnt", 32'(lock_loss_cnt_out), 32'd0);

    for (int i = 0; i < 5; i++) run_scenario(tbl[i]);

    // FAIL is held until re_align_in
    repeat (5) tick();
    check("fail_hold", 32'(align_fail_out), 32'd1);
    re_align_in = 1'b1;
    tick();
    re_align_in = 1'b0;
    check("realign_state",   32'(state_out),      32'd0);
    check("realign_fail",    32'(align_fail_out), 32'd0);
    check("realign_slipcnt", 32'(slip_cnt_out),   32'd0);

    // Three misses then a match keep lock; four misses lose it
    run_scenario(tbl[0]);
    frame_in = 8'h00;
    repeat (3) @(posedge clk_div_in);
    #1 frame_in = c_PAT;
    repeat (4) tick();
    check("miss3_aligned", 32'(aligned_out),       32'd1);
    check("miss3_losscnt", 32'(lock_loss_cnt_out), 32'd0);
    frame_in = 8'h00;
    wait_state("miss4_settle", 3'd1, 12);
    check("miss4_aligned", 32'(aligned_out),       32'd0);
    check("miss4_losscnt", 32'(lock_loss_cnt_out), 32'd1);
    frame_in = c_PAT;
    wait_state("miss4_check", 3'd2, c_WAIT + 2);
    wait_aligned("miss4_relock", 40);

    for (int i = 0; i < 4; i++) lose_lock("loss_loop");
    check("losscnt5", 32'(lock_loss_cnt_out), 32'd5);

    re_align_in = 1'b1;
    tick();
    re_align_in = 1'b0;
    check("realign_locked_state",   32'(state_out),         32'd0);
    check("realign_locked_aligned", 32'(aligned_out),       32'd0);
    check("realign_keeps_losscnt",  32'(lock_loss_cnt_out), 32'd5);
    wait_aligned("realign_relock", 40);

    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    check("rst_locked_state",   32'(state_out),         32'd0);
    check("rst_locked_outputs", 32'({bitslip_out, aligned_out, align_fail_out, slip_cnt_out}), 32'd0);
    check("rst_locked_losscnt", 32'(lock_loss_cnt_out), 32'd0);

    // dly_rdy_in dropped mid-SETTLE
    do_reset();
    frame_in   = c_PAT;
    dly_rdy_in = 1'b1;
    repeat (4) tick();
    check("settle_before_drop", 32'(state_out), 32'd1);
    dly_rdy_in = 1'b0;
    tick();
    check("drop_idle", 32'(state_out), 32'd0);
    re_align_in = 1'b1;
    tick();
    re_align_in = 1'b0;
    repeat (2) tick();
    check("drop_stays_idle", 32'(state_out), 32'd0);
    dly_rdy_in = 1'b1;
    wait_aligned("drop_relock", 40);

    // re_align_in coincides with the final matching CHECK word
    do_reset();
    frame_in   = c_PAT;
    dly_rdy_in = 1'b1;
    repeat (24) tick();
    check("last_check_state", 32'(state_out), 32'd2);
    re_align_in = 1'b1;
    tick();
    re_align_in = 1'b0;
    check("coincide_state",   32'(state_out),   32'd0);
    check("coincide_aligned", 32'(aligned_out), 32'd0);
    wait_aligned("coincide_relock", 40);
    check("coincide_slipcnt", 32'(slip_cnt_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
